mips_muldiv: RTL

//  Iterative multiply/divide unit with architectural HI/LO registers.

---
 rtl/mips_pkg.sv | 31 +++
 rtl/mips_muldiv.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/mips_pkg.sv
// Shared types for the multiply/divide unit: operation codes and FSM states.
package mips_pkg;

    localparam int unsigned MD_WIDTH = 32;

    typedef enum logic [2:0] {
        MD_MULT,
        MD_MULTU,
        MD_DIV,
        MD_DIVU,
        MD_MTHI,
        MD_MTLO
    } md_op_e;

    typedef enum logic [1:0] {
        MD_IDLE,
        MD_RUN,
        MD_FIX
    } md_state_e;

    // True for operations that run the iterative datapath.
    function automatic logic md_is_iter(input md_op_e op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    // True for operations that treat their operands as two's complement.
    function automatic logic md_is_signed(input md_op_e op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

endpackage

// File: rtl/mips_muldiv.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Shift-add multiply and restoring divide on magnitudes share one adder;
// signs are re-applied in the FIX state just before HI/LO are committed.
module mips_muldiv
    import mips_pkg::*;
#(
    parameter int unsigned WIDTH = MD_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  md_op_e           op_i,
    input  logic [WIDTH-1:0] operand_a_i,
    input  logic [WIDTH-1:0] operand_b_i,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned XW = WIDTH + 1;
    localparam int unsigned SW = WIDTH + 2;
    localparam int unsigned PW = 2 * WIDTH;

    md_state_e        state_q, state_d;
    md_op_e           op_q;
    logic [CW-1:0]    count_q;
    logic [XW-1:0]    acc_q;
    logic [XW-1:0]    opb_q;
    logic [WIDTH-1:0] mq_q;
    logic             neg_a_q, neg_b_q, b_zero_q;

    logic load_c, step_c, commit_c, mthi_c, mtlo_c;

    // Operand magnitudes at capture; XW bits so that abs(-2^(WIDTH-1)) fits.
    logic             a_neg_c, b_neg_c;
    logic [XW-1:0]    a_ext_c, b_ext_c, a_mag_c, b_mag_c;

    always_comb begin
        a_neg_c = md_is_signed(op_i) & operand_a_i[WIDTH-1];
        b_neg_c = md_is_signed(op_i) & operand_b_i[WIDTH-1];
        a_ext_c = {a_neg_c, operand_a_i};
        b_ext_c = {b_neg_c, operand_b_i};
        a_mag_c = a_neg_c ? (~a_ext_c + XW'(1)) : a_ext_c;
        b_mag_c = b_neg_c ? (~b_ext_c + XW'(1)) : b_ext_c;
    end

    // Shared adder: multiplicand add for MUL, trial subtract of the divisor for DIV.
    logic             is_mul_c;
    logic [XW-1:0]    shifted_c, add_a_c, add_b_c, mul_sel_c, div_rem_c;
    logic [SW-1:0]    sum_c;
    logic             div_ok_c;

    always_comb begin
        is_mul_c  = (op_q == MD_MULT) || (op_q == MD_MULTU);
        shifted_c = {acc_q[WIDTH-1:0], mq_q[WIDTH-1]};
        add_a_c   = is_mul_c ? acc_q : shifted_c;
        add_b_c   = is_mul_c ? opb_q : ~opb_q;
        sum_c     = {1'b0, add_a_c} + {1'b0, add_b_c} + SW'(!is_mul_c);
        mul_sel_c = mq_q[0] ? sum_c[XW-1:0] : acc_q;
        div_ok_c  = sum_c[XW];
        div_rem_c = div_ok_c ? sum_c[XW-1:0] : shifted_c;
    end

    // Sign correction and divide-by-zero override applied at commit.
    logic [PW-1:0]    product_c, prod_fix_c;
    logic [WIDTH-1:0] quot_c, rem_c, quot_fix_c, rem_fix_c, hi_res_c, lo_res_c;

    always_comb begin
        product_c  = {acc_q[WIDTH-1:0], mq_q};
        prod_fix_c = (neg_a_q ^ neg_b_q) ? (~product_c + PW'(1)) : product_c;
        quot_c     = mq_q;
        rem_c      = acc_q[WIDTH-1:0];
        quot_fix_c = (neg_a_q ^ neg_b_q) ? (~quot_c + WIDTH'(1)) : quot_c;
        rem_fix_c  = neg_a_q ? (~rem_c + WIDTH'(1)) : rem_c;
        if (is_mul_c) begin
            hi_res_c = prod_fix_c[PW-1:WIDTH];
            lo_res_c = prod_fix_c[WIDTH-1:0];
        end else if (b_zero_q) begin
            // Trial subtracts of zero always succeed, leaving |a| in the remainder.
            hi_res_c = rem_fix_c;
            lo_res_c = '1;
        end else begin
            hi_res_c = rem_fix_c;
            lo_res_c = quot_fix_c;
        end
    end

    // FSM state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= MD_IDLE;
        else       state_q <= state_d;
    end

    // FSM next state and datapath strobes.
    always_comb begin
        state_d  = state_q;
        load_c   = 1'b0;
        step_c   = 1'b0;
        commit_c = 1'b0;
        mthi_c   = 1'b0;
        mtlo_c   = 1'b0;
        case (state_q)
            MD_IDLE: begin
                if (start_i) begin
                    if (md_is_iter(op_i)) begin
                        load_c  = 1'b1;
                        state_d = MD_RUN;
                    end else if (op_i == MD_MTHI) begin
                        mthi_c = 1'b1;
                    end else if (op_i == MD_MTLO) begin
                        mtlo_c = 1'b1;
                    end
                end
            end
            MD_RUN: begin
                step_c = 1'b1;
                if (count_q == CW'(WIDTH - 1)) state_d = MD_FIX;
            end
            MD_FIX: begin
                commit_c = 1'b1;
                state_d  = MD_IDLE;
            end
            default: state_d = MD_IDLE;
        endcase
    end

    // Operand capture and one iteration per RUN cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            op_q     <= MD_MULT;
            count_q  <= '0;
            acc_q    <= '0;
            opb_q    <= '0;
            mq_q     <= '0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            b_zero_q <= 1'b0;
        end else if (load_c) begin
            op_q     <= op_i;
            count_q  <= '0;
            acc_q    <= '0;
            opb_q    <= b_mag_c;
            mq_q     <= a_mag_c[WIDTH-1:0];
            neg_a_q  <= a_neg_c;
            neg_b_q  <= b_neg_c;
            b_zero_q <= (operand_b_i == '0);
        end else if (step_c) begin
            count_q <= count_q + CW'(1);
            if (is_mul_c) begin
                acc_q <= {1'b0, mul_sel_c[XW-1:1]};
                mq_q  <= {mul_sel_c[0], mq_q[WIDTH-1:1]};
            end else begin
                acc_q <= div_rem_c;
                mq_q  <= {mq_q[WIDTH-2:0], div_ok_c};
            end
        end
    end

    // Architectural HI/LO: moves from IDLE, results at commit.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hi_o <= '0;
            lo_o <= '0;
        end else if (commit_c) begin
            hi_o <= hi_res_c;
            lo_o <= lo_res_c;
        end else begin
            if (mthi_c) hi_o <= operand_a_i;
            if (mtlo_c) lo_o <= operand_a_i;
        end
    end

    // Registered status flags.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            busy_o <= 1'b0;
            done_o <= 1'b0;
        end else begin
            busy_o <= (state_d != MD_IDLE);
            done_o <= commit_c;
        end
    end

endmodule
